// File: rtl/router_port_arbiter.sv
// Credit-based wormhole output arbiter: each output grants one input per cycle,
// holds the grant for a whole packet, and blocks when its downstream buffer is full.
module router_port_arbiter #(
    parameter int NIN     = 4,
    parameter int NOUT    = 4,
    parameter int W       = 8,
    parameter int CREDITS = 4,
    localparam int DW     = (NOUT > 1) ? $clog2(NOUT) : 1,
    localparam int CW     = $clog2(CREDITS + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NIN-1:0]     in_valid,
    input  logic [NIN*DW-1:0]  in_dest,
    input  logic [NIN-1:0]     in_tail,
    input  logic [NIN*W-1:0]   in_data,
    output logic [NIN-1:0]     in_ready,
    output logic [NOUT-1:0]    out_valid,
    output logic [NOUT*W-1:0]  out_data,
    output logic [NOUT-1:0]    out_tail,
    input  logic [NOUT-1:0]    credit_ret,
    output logic [NOUT-1:0]    credit_err
);
    localparam int IW = (NIN > 1) ? $clog2(NIN) : 1;

    logic [NIN-1:0]    w_req   [NOUT];
    logic [NIN-1:0]    w_grant [NOUT];
    logic [IW-1:0]     w_sel   [NOUT];
    logic [NOUT-1:0]   w_xfer;
    logic [NIN-1:0]    w_ready;
    logic [IW-1:0]     w_idx;
    logic              w_found;

    logic [NOUT-1:0]   r_locked;
    logic [IW-1:0]     r_owner [NOUT];
    logic [IW-1:0]     r_ptr   [NOUT];
    logic [CW-1:0]     r_cnt   [NOUT];
    logic [NOUT-1:0]   r_out_valid;
    logic [NOUT*W-1:0] r_out_data;
    logic [NOUT-1:0]   r_out_tail;
    logic [NOUT-1:0]   r_err;

    // Out-of-range destinations never equal any real output index, so they are never granted.
    for (genvar go = 0; go < NOUT; go++) begin : g_out
        for (genvar gi = 0; gi < NIN; gi++) begin : g_in
            assign w_req[go][gi] = in_valid[gi] && (in_dest[gi*DW +: DW] == DW'(go));
        end
    end

    always_comb begin
        w_idx   = '0;
        w_found = 1'b0;
        for (int o = 0; o < NOUT; o++) begin
            w_grant[o] = '0;
            w_sel[o]   = '0;
            w_found    = 1'b0;
            if (r_cnt[o] != '0) begin
                if (r_locked[o]) begin
                    if (w_req[o][r_owner[o]]) begin
                        w_grant[o][r_owner[o]] = 1'b1;
                        w_sel[o]               = r_owner[o];
                    end
                end else begin
                    for (int k = 0; k < NIN; k++) begin
                        w_idx = IW'((int'(r_ptr[o]) + k) % NIN);
                        if (!w_found && w_req[o][w_idx]) begin
                            w_found           = 1'b1;
                            w_grant[o][w_idx] = 1'b1;
                            w_sel[o]          = w_idx;
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        w_ready = '0;
        w_xfer  = '0;
        for (int o = 0; o < NOUT; o++) begin
            w_xfer[o] = |w_grant[o];
            if (!rst) begin
                w_ready = w_ready | w_grant[o];
            end
        end
    end

    assign in_ready = w_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_locked    <= '0;
            r_out_valid <= '0;
            r_out_data  <= '0;
            r_out_tail  <= '0;
            r_err       <= '0;
            for (int o = 0; o < NOUT; o++) begin
                r_owner[o] <= '0;
                r_ptr[o]   <= '0;
                r_cnt[o]   <= CW'(CREDITS);
            end
        end else begin
            for (int o = 0; o < NOUT; o++) begin
                r_out_valid[o] <= w_xfer[o];
                if (w_xfer[o]) begin
                    r_out_data[o*W +: W] <= in_data[int'(w_sel[o])*W +: W];
                    r_out_tail[o]        <= in_tail[w_sel[o]];
                    if (in_tail[w_sel[o]]) begin
                        r_locked[o] <= 1'b0;
                        r_ptr[o]    <= IW'((int'(w_sel[o]) + 1) % NIN);
                    end else begin
                        r_locked[o] <= 1'b1;
                        r_owner[o]  <= w_sel[o];
                    end
                end
                // A simultaneous send and credit return cancel out.
                if (w_xfer[o] && !credit_ret[o]) begin
                    r_cnt[o] <= r_cnt[o] - CW'(1);
                end else if (!w_xfer[o] && credit_ret[o]) begin
                    if (r_cnt[o] == CW'(CREDITS)) begin
                        r_err[o] <= 1'b1;
                    end else begin
                        r_cnt[o] <= r_cnt[o] + CW'(1);
                    end
                end
            end
        end
    end

    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign out_tail   = r_out_tail;
    assign credit_err = r_err;

endmodule

// File: tb/tb_router_port_arbiter.sv
// Directed and random stimulus for router_port_arbiter, checked against a
// packet-level reference model of the output arbiters and credit counters.
module tb_router_port_arbiter;
    localparam int NIN = 4, NOUT = 4, W = 8, CREDITS = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [NIN-1:0]    in_valid;
    logic [NIN*2-1:0]  in_dest;
    logic [NIN-1:0]    in_tail;
    logic [NIN*W-1:0]  in_data;
    logic [NIN-1:0]    in_ready;
    logic [NOUT-1:0]   out_valid;
    logic [NOUT*W-1:0] out_data;
    logic [NOUT-1:0]   out_tail;
    logic [NOUT-1:0]   credit_ret;
    logic [NOUT-1:0]   credit_err;

    router_port_arbiter #(.NIN(NIN), .NOUT(NOUT), .W(W), .CREDITS(CREDITS)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_dest(in_dest),
        .in_tail(in_tail), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_tail(out_tail),
        .credit_ret(credit_ret), .credit_err(credit_err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: per output, whether a packet is open, who owns it,
    // where the next fair scan starts, and how many free downstream slots remain.
    int            m_locked [NOUT];
    int            m_owner  [NOUT];
    int            m_ptr    [NOUT];
    int            m_cnt    [NOUT];
    int            m_g      [NOUT];
    logic [NOUT-1:0]   m_ov, m_ot, m_err;
    logic [NOUT*W-1:0] m_od;
    logic [NIN-1:0]    exp_ready;

    function automatic int dest_of(int i);
        return int'(in_dest[i*2 +: 2]);
    endfunction

    task automatic model_reset();
        for (int o = 0; o < NOUT; o++) begin
            m_locked[o] = 0; m_owner[o] = 0; m_ptr[o] = 0; m_cnt[o] = CREDITS;
        end
        m_ov = '0; m_ot = '0; m_err = '0; m_od = '0;
    endtask

    task automatic model_grant();
        exp_ready = '0;
        for (int o = 0; o < NOUT; o++) begin
            m_g[o] = -1;
            if (m_cnt[o] > 0) begin
                if (m_locked[o] != 0) begin
                    if (in_valid[m_owner[o]] && dest_of(m_owner[o]) == o) m_g[o] = m_owner[o];
                end else begin
                    for (int k = 0; k < NIN; k++) begin
                        int i;
                        i = (m_ptr[o] + k) % NIN;
                        if (m_g[o] < 0 && in_valid[i] && dest_of(i) == o) m_g[o] = i;
                    end
                end
            end
            if (!rst && m_g[o] >= 0) exp_ready[m_g[o]] = 1'b1;
        end
    endtask

    task automatic model_clock();
        if (rst) begin
            model_reset();
        end else begin
            for (int o = 0; o < NOUT; o++) begin
                int g;
                g = m_g[o];
                m_ov[o] = (g >= 0);
                if (g >= 0) begin
                    m_od[o*W +: W] = in_data[g*W +: W];
                    m_ot[o] = in_tail[g];
                    if (in_tail[g]) begin
                        m_locked[o] = 0;
                        m_ptr[o] = (g + 1) % NIN;
                    end else begin
                        m_locked[o] = 1;
                        m_owner[o] = g;
                    end
                end
                if (g >= 0 && !credit_ret[o]) m_cnt[o] = m_cnt[o] - 1;
                else if (g < 0 && credit_ret[o]) begin
                    if (m_cnt[o] == CREDITS) m_err[o] = 1'b1;
                    else m_cnt[o] = m_cnt[o] + 1;
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: check combinational ready, advance, then check registered outputs.
    task automatic step(input string tag);
        #1;
        model_grant();
        chk({tag, ":in_ready"}, 32'(in_ready), 32'(exp_ready));
        model_clock();
        @(posedge clk);
        @(negedge clk);
        chk({tag, ":out_valid"}, 32'(out_valid), 32'(m_ov));
        chk({tag, ":out_tail"}, 32'(out_tail), 32'(m_ot));
        chk({tag, ":out_data"}, 32'(out_data), 32'(m_od));
        chk({tag, ":credit_err"}, 32'(credit_err), 32'(m_err));
        $display("[TB] %s t=%0t valid=%b ready=%b out_valid=%b out_data=%h err=%b",
                 tag, $time, in_valid, in_ready, out_valid, out_data, credit_err);
    endtask

    task automatic set_dest(input int d0, input int d1, input int d2, input int d3);
        in_dest = {2'(d3), 2'(d2), 2'(d1), 2'(d0)};
    endtask

    initial begin
        rst = 1'b1; in_valid = '0; in_dest = '0; in_tail = '0; in_data = '0; credit_ret = '0;
        model_reset();
        @(negedge clk);
        in_valid = 4'b1111;
        #1 chk("rst_ready_zero", 32'(in_ready), 32'h0);
        step("reset");
        step("reset");
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_data", 32'(out_data), 32'h0);
        chk("rst_credit_err", 32'(credit_err), 32'h0);

        // All four inputs to output 2, single-flit packets, credits refilled every cycle.
        rst = 1'b0; in_valid = 4'b1111; set_dest(2, 2, 2, 2); in_tail = 4'b1111;
        credit_ret = 4'b0100;
        for (int c = 0; c < 8; c++) begin
            in_data = $urandom;
            #1 chk("rr_grant", 32'(in_ready), 32'(1 << (c % 4)));
            step("rr");
        end

        // Input 1 holds output 0 for a 3-flit packet while input 2 waits.
        in_valid = 4'b0110; set_dest(0, 0, 0, 0); credit_ret = 4'b0001;
        for (int c = 0; c < 3; c++) begin
            in_data = $urandom;
            in_tail = (c == 2) ? 4'b0110 : 4'b0100;
            #1 chk("lock_owner", 32'(in_ready), 32'h2);
            step("lock");
        end
        in_valid = 4'b0100; in_data = $urandom;
        #1 chk("lock_release", 32'(in_ready), 32'h4);
        step("lock_rel");

        // Credit exhaustion on output 3.
        rst = 1'b1; in_valid = '0; credit_ret = '0;
        step("rst2");
        rst = 1'b0; in_valid = 4'b0001; set_dest(3, 0, 0, 0); in_tail = 4'b1111;
        for (int c = 0; c < 4; c++) begin
            in_data = $urandom;
            #1 chk("credit_take", 32'(in_ready), 32'h1);
            step("credit");
        end
        #1 chk("credit_block", 32'(in_ready), 32'h0);
        step("credit_blk");
        credit_ret = 4'b1000;
        #1 chk("credit_same_cycle", 32'(in_ready), 32'h0);
        step("credit_ret");
        credit_ret = 4'b0000;
        #1 chk("credit_regrant", 32'(in_ready), 32'h1);
        step("credit_go");

        // Output 1: two sends, then send with credit, then refill and overflow.
        in_valid = 4'b0001; set_dest(1, 0, 0, 0); credit_ret = '0;
        step("c1_send"); step("c1_send");
        credit_ret = 4'b0010;
        step("c1_both");
        in_valid = '0;
        step("c1_ret"); step("c1_ret");
        chk("c1_no_err_yet", 32'(credit_err), 32'h0);
        step("c1_over");
        chk("c1_err", 32'(credit_err & 4'b0010), 32'h2);
        credit_ret = '0;

        // Independent outputs in the same cycle.
        in_valid = 4'b1001; set_dest(0, 0, 0, 1); in_tail = 4'b1001; in_data = 32'hA5_00_00_3C;
        credit_ret = 4'b0011;
        #1 chk("parallel_ready", 32'(in_ready), 32'h9);
        step("parallel");
        chk("parallel_data", 32'(out_data[15:0]), 32'hA53C);

        // Reset during an open packet drops the lock.
        rst = 1'b1; in_valid = '0; credit_ret = '0;
        step("rst3");
        rst = 1'b0; in_valid = 4'b0011; set_dest(0, 0, 0, 0); in_tail = 4'b0010;
        step("mid_pkt"); step("mid_pkt");
        rst = 1'b1;
        #1 chk("rst_mid_ready", 32'(in_ready), 32'h0);
        step("rst_mid");
        chk("rst_mid_valid", 32'(out_valid), 32'h0);
        rst = 1'b0; in_valid = 4'b0010;
        #1 chk("after_rst_grant", 32'(in_ready), 32'h2);
        step("after_rst");

        // Randomized traffic against the model.
        for (int c = 0; c < 400; c++) begin
            rst        = ($urandom_range(0, 99) == 0);
            in_valid   = 4'($urandom);
            in_dest    = 8'($urandom);
            in_tail    = 4'($urandom);
            in_data    = $urandom;
            for (int o = 0; o < NOUT; o++) credit_ret[o] = ($urandom_range(0, 3) == 0);
            step("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout");
        $fatal(1, "timeout");
    end
endmodule
